// File: rtl/fetch_unit.sv
// fetch_unit: PC sequencer feeding a one-cycle-latency instruction memory and a small decode queue.
// Optional build macro FETCH_UNIT_PERF_CNT_EN adds the handshake counter output o_fetch_count.
module fetch_unit #(
    parameter int unsigned               DATA_WIDTH_P      = 32,
    parameter int unsigned               IMEM_ADDR_WIDTH_P = 8,
    parameter int unsigned               FIFO_DEPTH_P      = 4,
    parameter logic [DATA_WIDTH_P-1:0]   RESET_PC_P        = 32'h00000000
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          i_enable,
    output logic                          o_imem_req,
    output logic [IMEM_ADDR_WIDTH_P-1:0]  o_imem_addr,
    input  logic [DATA_WIDTH_P-1:0]       i_imem_rd_data,
    input  logic                          i_redirect,
    input  logic [DATA_WIDTH_P-1:0]       i_redirect_pc,
    output logic                          o_instr_valid,
    input  logic                          i_instr_ready,
    output logic [DATA_WIDTH_P-1:0]       o_instr,
    output logic [DATA_WIDTH_P-1:0]       o_pc,
    output logic [DATA_WIDTH_P-1:0]       o_pcp4
`ifdef FETCH_UNIT_PERF_CNT_EN
    ,
    output logic [31:0]                   o_fetch_count
`endif
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH_P);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [DATA_WIDTH_P-1:0] ALIGN_MASK = {{(DATA_WIDTH_P-2){1'b1}}, 2'b00};
    localparam logic [DATA_WIDTH_P-1:0] PC_STEP    = {{(DATA_WIDTH_P-3){1'b0}}, 3'b100};
    localparam logic [PTR_W-1:0]        PTR_ONE    = {{(PTR_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0]        CNT_ONE    = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0]        DEPTH_CNT  = CNT_W'(FIFO_DEPTH_P);
    localparam logic [CNT_W:0]          DEPTH_OCC  = (CNT_W+1)'(FIFO_DEPTH_P);

    logic [DATA_WIDTH_P-1:0] pc_r;
    logic [DATA_WIDTH_P-1:0] req_pc_r;
    logic                    inflight_r;
    logic [CNT_W-1:0]        count_r;
    logic [PTR_W-1:0]        rd_ptr_r;
    logic [PTR_W-1:0]        wr_ptr_r;
    logic [DATA_WIDTH_P-1:0] instr_q_r [FIFO_DEPTH_P];
    logic [DATA_WIDTH_P-1:0] pc_q_r    [FIFO_DEPTH_P];

    logic [DATA_WIDTH_P-1:0] redirect_pc_s;
    logic [DATA_WIDTH_P-1:0] issue_pc_s;
    logic [DATA_WIDTH_P-1:0] next_pc_s;
    logic [CNT_W:0]          occupancy_s;
    logic                    req_s;
    logic                    valid_s;
    logic                    pop_s;
    logic                    push_s;

    // Request credit, issue address, next PC and queue handshake decode.
    // A redirect both kills the response arriving this cycle and masks the head.
    always_comb begin
        redirect_pc_s = i_redirect_pc & ALIGN_MASK;
        occupancy_s   = {1'b0, count_r} + {{CNT_W{1'b0}}, inflight_r};
        issue_pc_s    = pc_r;
        req_s         = 1'b0;
        next_pc_s     = pc_r;
        if (i_redirect) begin
            issue_pc_s = redirect_pc_s;
        end else begin
            issue_pc_s = pc_r;
        end
        if (i_enable && !reset && (occupancy_s < DEPTH_OCC)) begin
            req_s = 1'b1;
        end else begin
            req_s = 1'b0;
        end
        if (req_s) begin
            next_pc_s = issue_pc_s + PC_STEP;
        end else begin
            next_pc_s = issue_pc_s;
        end
        valid_s = (count_r != {CNT_W{1'b0}}) && !i_redirect;
        pop_s   = valid_s && i_instr_ready;
        push_s  = inflight_r && !i_redirect && ((count_r != DEPTH_CNT) || pop_s);
    end

    assign o_imem_req    = req_s;
    assign o_imem_addr   = issue_pc_s[IMEM_ADDR_WIDTH_P+1:2];
    assign o_instr_valid = valid_s;
    assign o_instr       = instr_q_r[rd_ptr_r];
    assign o_pc          = pc_q_r[rd_ptr_r];
    assign o_pcp4        = o_pc + PC_STEP;

    // PC, in-flight tracking and queue pointers/occupancy.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_r       <= RESET_PC_P & ALIGN_MASK;
            req_pc_r   <= {DATA_WIDTH_P{1'b0}};
            inflight_r <= 1'b0;
            count_r    <= {CNT_W{1'b0}};
            rd_ptr_r   <= {PTR_W{1'b0}};
            wr_ptr_r   <= {PTR_W{1'b0}};
        end else begin
            pc_r       <= next_pc_s;
            req_pc_r   <= issue_pc_s;
            inflight_r <= req_s;
            if (i_redirect) begin
                count_r  <= {CNT_W{1'b0}};
                rd_ptr_r <= {PTR_W{1'b0}};
                wr_ptr_r <= {PTR_W{1'b0}};
            end else begin
                if (push_s) begin
                    wr_ptr_r <= wr_ptr_r + PTR_ONE;
                end
                if (pop_s) begin
                    rd_ptr_r <= rd_ptr_r + PTR_ONE;
                end
                case ({push_s, pop_s})
                    2'b10:   count_r <= count_r + CNT_ONE;
                    2'b01:   count_r <= count_r - CNT_ONE;
                    default: count_r <= count_r;
                endcase
            end
        end
    end

    // Queue storage: response word together with the PC it was fetched from.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < int'(FIFO_DEPTH_P); i++) begin
                instr_q_r[i] <= {DATA_WIDTH_P{1'b0}};
                pc_q_r[i]    <= {DATA_WIDTH_P{1'b0}};
            end
        end else if (push_s) begin
            instr_q_r[wr_ptr_r] <= i_imem_rd_data;
            pc_q_r[wr_ptr_r]    <= req_pc_r;
        end
    end

`ifdef FETCH_UNIT_PERF_CNT_EN
    logic [31:0] fetch_count_r;

    // Completed-handshake counter, free-running modulo 2^32.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_count_r <= 32'd0;
        end else if (pop_s) begin
            fetch_count_r <= fetch_count_r + 32'd1;
        end
    end

    assign o_fetch_count = fetch_count_r;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios plus random traffic checked against a queue-based reference model.
module tb_fetch_unit;

    localparam int DW     = 32;
    localparam int AW     = 8;
    localparam int D      = 4;
    localparam logic [31:0] RST_PC = 32'h00000000;

    logic          clk = 1'b0;
    logic          reset;
    logic          en;
    logic          o_imem_req;
    logic [AW-1:0] o_imem_addr;
    logic [DW-1:0] rd_data;
    logic          redirect;
    logic [DW-1:0] rpc;
    logic          o_instr_valid;
    logic          ready;
    logic [DW-1:0] o_instr;
    logic [DW-1:0] o_pc;
    logic [DW-1:0] o_pcp4;
`ifdef FETCH_UNIT_PERF_CNT_EN
    logic [31:0]   o_fetch_count;
`endif

    fetch_unit #(
        .DATA_WIDTH_P(DW), .IMEM_ADDR_WIDTH_P(AW), .FIFO_DEPTH_P(D), .RESET_PC_P(RST_PC)
    ) dut (
        .clk(clk), .reset(reset), .i_enable(en),
        .o_imem_req(o_imem_req), .o_imem_addr(o_imem_addr), .i_imem_rd_data(rd_data),
        .i_redirect(redirect), .i_redirect_pc(rpc),
        .o_instr_valid(o_instr_valid), .i_instr_ready(ready),
        .o_instr(o_instr), .o_pc(o_pc), .o_pcp4(o_pcp4)
`ifdef FETCH_UNIT_PERF_CNT_EN
        , .o_fetch_count(o_fetch_count)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } entry_t;

    logic [31:0] mem [256];
    entry_t      q[$];
    logic [31:0] m_pc;
    logic [31:0] m_infl_pc;
    bit          m_infl;
    int unsigned m_hs;
    int          n_checks = 0;
    int          n_fail   = 0;
    int          req_cnt  = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_pc      = RST_PC;
        m_infl    = 1'b0;
        m_infl_pc = 32'd0;
        m_hs      = 0;
    endtask

    // One clock cycle: inputs already set at the falling edge; check, then advance the model.
    task automatic step();
        logic [31:0] ipc;
        bit er;
        bit ev;
        #1;
        er  = en && ((q.size() + int'(m_infl)) < D);
        ipc = redirect ? (rpc & 32'hFFFFFFFC) : m_pc;
        ev  = (q.size() > 0) && !redirect;
        check("imem_req", {31'd0, o_imem_req}, {31'd0, er});
        check("imem_addr", {24'd0, o_imem_addr}, {24'd0, ipc[9:2]});
        check("instr_valid", {31'd0, o_instr_valid}, {31'd0, ev});
        if (ev) begin
            check("instr", o_instr, q[0].instr);
            check("pc", o_pc, q[0].pc);
            check("pcp4", o_pcp4, q[0].pc + 32'd4);
        end
`ifdef FETCH_UNIT_PERF_CNT_EN
        check("fetch_count", o_fetch_count, m_hs);
`endif
        if (er) req_cnt++;
        @(posedge clk);
        if (redirect) begin
            q.delete();
        end else begin
            if (ev && ready) begin
                void'(q.pop_front());
                m_hs++;
            end
            if (m_infl) q.push_back({mem[m_infl_pc[9:2]], m_infl_pc});
        end
        m_infl    = er;
        m_infl_pc = ipc;
        m_pc      = er ? ipc + 32'd4 : ipc;
        #1;
        rd_data = er ? mem[ipc[9:2]] : $urandom;
        @(negedge clk);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = $urandom;
        reset = 1'b1; en = 1'b1; ready = 1'b1; redirect = 1'b0; rpc = 32'd0; rd_data = 32'd0;
        model_reset();
        @(negedge clk);
        #1;
        check("rst_req", {31'd0, o_imem_req}, 32'd0);
        check("rst_valid", {31'd0, o_instr_valid}, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // Streaming from reset with decode always ready.
        for (int i = 0; i < 10; i++) step();

        // Drain, then stall decode for ten cycles from an empty pipe.
        en = 1'b0;
        for (int i = 0; i < 4; i++) step();
        en = 1'b1; ready = 1'b0; req_cnt = 0;
        for (int i = 0; i < 10; i++) step();
        check("stall_reqs", req_cnt, 32'd4);
        ready = 1'b1;
        for (int i = 0; i < 8; i++) step();

        // Redirect to an unaligned target mid-stream.
        redirect = 1'b1; rpc = 32'h00000043;
        #1;
        check("redir_addr", {24'd0, o_imem_addr}, 32'd16);
        step();
        redirect = 1'b0;
        for (int i = 0; i < 6; i++) step();

        // PC wrap at the top of the address space.
        redirect = 1'b1; rpc = 32'hFFFFFFFC;
        #1;
        check("wrap_addr_hi", {24'd0, o_imem_addr}, 32'd255);
        step();
        redirect = 1'b0;
        #1;
        check("wrap_addr_lo", {24'd0, o_imem_addr}, 32'd0);
        for (int i = 0; i < 6; i++) step();

        // Reset with three entries queued and one in flight.
        en = 1'b0; ready = 1'b1;
        for (int i = 0; i < 4; i++) step();
        en = 1'b1; ready = 1'b0;
        for (int i = 0; i < 4; i++) step();
        #2;
        reset = 1'b1;
        #1;
        check("midrst_valid", {31'd0, o_instr_valid}, 32'd0);
        check("midrst_req", {31'd0, o_imem_req}, 32'd0);
        model_reset();
        @(posedge clk);
        #1 rd_data = $urandom;
        @(negedge clk);
        reset = 1'b0; ready = 1'b1;
        for (int i = 0; i < 6; i++) step();

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            en       = ($urandom_range(0, 3) != 0);
            ready    = ($urandom_range(0, 2) != 0);
            redirect = ($urandom_range(0, 15) == 0);
            rpc      = $urandom;
            step();
        end
        redirect = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
